reg_xfer_seq: RTL and testbench

- Command-driven sequencer that generates every ctl_reg_* control input of reg_control, plus ctl_sw_4.
- Converts one-word register-transfer commands into cycle-accurate select, output-enable and exchange strobes: GP or system register, 8 or 16 bit, read or write, EX/EXX.
- Sits between the future microcode/timing unit and reg_control / reg_file.
- Replaces hand-driven control stimulus with a single valid/ready command port.

---
 rtl/reg_xfer_seq_pkg.sv | 34 +++
 rtl/reg_xfer_seq_if.sv | 27 ++
 rtl/reg_xfer_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_seq_pkg.sv
// rtl/reg_xfer_seq_pkg.sv - shared command, selector and state types for reg_xfer_seq
package reg_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_RD8    = 3'd1,
      OP_RD16   = 3'd2,
      OP_WR8    = 3'd3,
      OP_WR16   = 3'd4,
      OP_EXX    = 3'd5,
      OP_EXAF   = 3'd6,
      OP_EXDEHL = 3'd7
   } cmd_op_t;

   typedef enum logic [1:0] {
      SYS_SP = 2'd0,
      SYS_WZ = 2'd1,
      SYS_PC = 2'd2,
      SYS_IR = 2'd3
   } sys_sel_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PH_LO = 3'd1,
      ST_PH_HI = 3'd2,
      ST_WHOLD = 3'd3,
      ST_EXCH  = 3'd4,
      ST_GAP   = 3'd5
   } seq_state_t;

   localparam int WR_HOLD_MAX = 3;
   localparam int EX_GAP_MAX  = 3;

endpackage

// File: rtl/reg_xfer_seq_if.sv
// rtl/reg_xfer_seq_if.sv - valid/ready command port of reg_xfer_seq
interface reg_xfer_seq_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_sys;
   logic [2:0] cmd_sel;
   logic       cmd_hi;
   logic       cmd_sp;
   logic       cmd_ixiy;
   logic       cmd_ix;
   logic       cmd_bridge;

   modport master (
      output cmd_valid, cmd_op, cmd_sys, cmd_sel, cmd_hi, cmd_sp,
             cmd_ixiy, cmd_ix, cmd_bridge,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sys, cmd_sel, cmd_hi, cmd_sp,
             cmd_ixiy, cmd_ix, cmd_bridge,
      output cmd_ready
   );

endinterface

// File: rtl/reg_xfer_seq.sv
// rtl/reg_xfer_seq.sv - turns one-word register-transfer commands into reg_control strobes
module reg_xfer_seq
   import reg_seq_pkg::*;
#(
   parameter int WR_HOLD = 1,
   parameter int EX_GAP  = 1
) (
   input  logic              clk,
   input  logic              reset,
   reg_xfer_seq_if.slave     cmd,
   output logic              ctl_reg_sel_gp,
   output logic              ctl_reg_sel_gp_16,
   output logic              ctl_reg_sel_sp,
   output logic              ctl_reg_gp_oe,
   output logic              ctl_reg_use_sp,
   output logic              ctl_reg_sel_wz,
   output logic              ctl_reg_sel_pc,
   output logic              ctl_reg_sel_ir,
   output logic              ctl_reg_sel_sys_hi,
   output logic              ctl_reg_sel_sys_lo,
   output logic              ctl_reg_sys_oe,
   output logic              ctl_reg_use_ixiy,
   output logic              ctl_reg_use_ix,
   output logic              ctl_reg_exx,
   output logic              ctl_reg_ex_af,
   output logic              ctl_reg_ex_de_hl,
   output logic [2:0]        reg_sel,
   output logic              ctl_sw_4,
   output logic              done,
   output logic              err
);

   // Counters reload with "cycles remaining minus one" after the first cycle of a phase.
   localparam logic [1:0] WR_CNT = 2'(WR_HOLD - 2);
   localparam logic [1:0] EX_CNT = 2'(EX_GAP - 1);

   seq_state_t state_q, state_d;
   cmd_op_t    op_q, op_d;
   logic       sys_q, sys_d;
   logic [2:0] sel_q, sel_d;
   logic       sp_q, sp_d;
   logic       ixiy_q, ixiy_d;
   logic       ix_q, ix_d;
   logic       bridge_q, bridge_d;
   logic       half_q, half_d;
   logic [1:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   cmd_op_t in_op;
   logic    in_wide, in_ex, in_xfer, in_illegal;
   logic    is_wr, is_wide, end_phase;

   always_comb begin
      in_op      = cmd_op_t'(cmd.cmd_op);
      in_wide    = (in_op == OP_RD16) || (in_op == OP_WR16);
      in_ex      = (in_op == OP_EXX) || (in_op == OP_EXAF) || (in_op == OP_EXDEHL);
      in_xfer    = (in_op != OP_NOP) && !in_ex;
      in_illegal = cmd.cmd_sys && ((in_xfer && cmd.cmd_sel[2]) || in_ex);
      is_wr      = (op_q == OP_WR8) || (op_q == OP_WR16);
      is_wide    = (op_q == OP_RD16) || (op_q == OP_WR16);
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sys_d     = sys_q;
      sel_d     = sel_q;
      sp_d      = sp_q;
      ixiy_d    = ixiy_q;
      ix_d      = ix_q;
      bridge_d  = bridge_q;
      half_d    = half_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = err_q;
      end_phase = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               op_d     = in_op;
               sys_d    = cmd.cmd_sys;
               sel_d    = cmd.cmd_sel;
               sp_d     = cmd.cmd_sp;
               ixiy_d   = cmd.cmd_ixiy;
               ix_d     = cmd.cmd_ix;
               bridge_d = cmd.cmd_bridge;
               half_d   = cmd.cmd_sys && !in_wide && cmd.cmd_hi;
               cnt_d    = WR_CNT;
               if (in_illegal) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else if (in_op == OP_NOP) begin
                  done_d = 1'b1;
               end else if (in_ex) begin
                  state_d = ST_EXCH;
               end else begin
                  state_d = half_d ? ST_PH_HI : ST_PH_LO;
               end
            end
         end
         ST_PH_LO, ST_PH_HI: begin
            if (is_wr && (WR_HOLD > 1)) state_d = ST_WHOLD;
            else                        end_phase = 1'b1;
         end
         ST_WHOLD: begin
            if (cnt_q == 2'd0) end_phase = 1'b1;
            else               cnt_d = cnt_q - 2'd1;
         end
         ST_EXCH: begin
            if (EX_GAP == 0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_GAP;
               cnt_d   = EX_CNT;
            end
         end
         ST_GAP: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A 16-bit system transfer runs its low phase first, then the high phase.
      if (end_phase) begin
         if (sys_q && is_wide && !half_q) begin
            state_d = ST_PH_HI;
            half_d  = 1'b1;
            cnt_d   = WR_CNT;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NOP;
         sys_q    <= 1'b0;
         sel_q    <= 3'd0;
         sp_q     <= 1'b0;
         ixiy_q   <= 1'b0;
         ix_q     <= 1'b0;
         bridge_q <= 1'b0;
         half_q   <= 1'b0;
         cnt_q    <= 2'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sys_q    <= sys_d;
         sel_q    <= sel_d;
         sp_q     <= sp_d;
         ixiy_q   <= ixiy_d;
         ix_q     <= ix_d;
         bridge_q <= bridge_d;
         half_q   <= half_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign cmd.cmd_ready = (state_q == ST_IDLE);
   assign done          = done_q;
   assign err           = err_q;

   always_comb begin
      ctl_reg_sel_gp     = 1'b0;
      ctl_reg_sel_gp_16  = 1'b0;
      ctl_reg_sel_sp     = 1'b0;
      ctl_reg_gp_oe      = 1'b0;
      ctl_reg_use_sp     = 1'b0;
      ctl_reg_sel_wz     = 1'b0;
      ctl_reg_sel_pc     = 1'b0;
      ctl_reg_sel_ir     = 1'b0;
      ctl_reg_sel_sys_hi = 1'b0;
      ctl_reg_sel_sys_lo = 1'b0;
      ctl_reg_sys_oe     = 1'b0;
      ctl_reg_use_ixiy   = 1'b0;
      ctl_reg_use_ix     = 1'b0;
      ctl_reg_exx        = 1'b0;
      ctl_reg_ex_af      = 1'b0;
      ctl_reg_ex_de_hl   = 1'b0;
      reg_sel            = 3'd0;
      ctl_sw_4           = 1'b0;
      if ((state_q == ST_PH_LO) || (state_q == ST_PH_HI) || (state_q == ST_WHOLD)) begin
         ctl_reg_use_ixiy = ixiy_q;
         ctl_reg_use_ix   = ix_q;
         ctl_sw_4         = bridge_q;
         if (!sys_q) begin
            ctl_reg_sel_gp    = 1'b1;
            ctl_reg_sel_gp_16 = is_wide;
            ctl_reg_sel_sp    = is_wide && sp_q;
            ctl_reg_gp_oe     = !is_wr;
            reg_sel           = sel_q;
         end else begin
            case (sys_sel_t'(sel_q[1:0]))
               SYS_SP:  ctl_reg_use_sp = 1'b1;
               SYS_WZ:  ctl_reg_sel_wz = 1'b1;
               SYS_PC:  ctl_reg_sel_pc = 1'b1;
               default: ctl_reg_sel_ir = 1'b1;
            endcase
            ctl_reg_sel_sys_hi = half_q;
            ctl_reg_sel_sys_lo = !half_q;
            ctl_reg_sys_oe     = !is_wr;
         end
      end else if (state_q == ST_EXCH) begin
         ctl_reg_exx      = (op_q == OP_EXX);
         ctl_reg_ex_af    = (op_q == OP_EXAF);
         ctl_reg_ex_de_hl = (op_q == OP_EXDEHL);
      end
   end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb/tb_reg_xfer_seq.sv - directed self-checking bench for reg_xfer_seq (WR_HOLD=2, EX_GAP=2)
module tb_reg_xfer_seq;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   reg_xfer_seq_if cmd_if ();

   logic ctl_reg_sel_gp, ctl_reg_sel_gp_16, ctl_reg_sel_sp, ctl_reg_gp_oe;
   logic ctl_reg_use_sp, ctl_reg_sel_wz, ctl_reg_sel_pc, ctl_reg_sel_ir;
   logic ctl_reg_sel_sys_hi, ctl_reg_sel_sys_lo, ctl_reg_sys_oe;
   logic ctl_reg_use_ixiy, ctl_reg_use_ix;
   logic ctl_reg_exx, ctl_reg_ex_af, ctl_reg_ex_de_hl;
   logic [2:0] reg_sel;
   logic ctl_sw_4, done, err;

   reg_xfer_seq #(.WR_HOLD(2), .EX_GAP(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .cmd                (cmd_if.slave),
      .ctl_reg_sel_gp     (ctl_reg_sel_gp),
      .ctl_reg_sel_gp_16  (ctl_reg_sel_gp_16),
      .ctl_reg_sel_sp     (ctl_reg_sel_sp),
      .ctl_reg_gp_oe      (ctl_reg_gp_oe),
      .ctl_reg_use_sp     (ctl_reg_use_sp),
      .ctl_reg_sel_wz     (ctl_reg_sel_wz),
      .ctl_reg_sel_pc     (ctl_reg_sel_pc),
      .ctl_reg_sel_ir     (ctl_reg_sel_ir),
      .ctl_reg_sel_sys_hi (ctl_reg_sel_sys_hi),
      .ctl_reg_sel_sys_lo (ctl_reg_sel_sys_lo),
      .ctl_reg_sys_oe     (ctl_reg_sys_oe),
      .ctl_reg_use_ixiy   (ctl_reg_use_ixiy),
      .ctl_reg_use_ix     (ctl_reg_use_ix),
      .ctl_reg_exx        (ctl_reg_exx),
      .ctl_reg_ex_af      (ctl_reg_ex_af),
      .ctl_reg_ex_de_hl   (ctl_reg_ex_de_hl),
      .reg_sel            (reg_sel),
      .ctl_sw_4           (ctl_sw_4),
      .done               (done),
      .err                (err)
   );

   localparam logic [16:0] C_SEL_GP  = 17'h10000;
   localparam logic [16:0] C_GP_16   = 17'h08000;
   localparam logic [16:0] C_SEL_SP  = 17'h04000;
   localparam logic [16:0] C_GP_OE   = 17'h02000;
   localparam logic [16:0] C_USE_SP  = 17'h01000;
   localparam logic [16:0] C_WZ      = 17'h00800;
   localparam logic [16:0] C_PC      = 17'h00400;
   localparam logic [16:0] C_IR      = 17'h00200;
   localparam logic [16:0] C_HI      = 17'h00100;
   localparam logic [16:0] C_LO      = 17'h00080;
   localparam logic [16:0] C_SYS_OE  = 17'h00040;
   localparam logic [16:0] C_IXIY    = 17'h00020;
   localparam logic [16:0] C_IX      = 17'h00010;
   localparam logic [16:0] C_EXX     = 17'h00008;
   localparam logic [16:0] C_EXAF    = 17'h00004;
   localparam logic [16:0] C_EXDEHL  = 17'h00002;
   localparam logic [16:0] C_SW4     = 17'h00001;
   localparam logic [16:0] C_NONE    = 17'h00000;

   // status = {cmd_ready, done, err}
   localparam logic [2:0] S_BUSY      = 3'b000;
   localparam logic [2:0] S_IDLE      = 3'b100;
   localparam logic [2:0] S_DONE      = 3'b110;
   localparam logic [2:0] S_BUSY_E    = 3'b001;
   localparam logic [2:0] S_IDLE_E    = 3'b101;
   localparam logic [2:0] S_DONE_E    = 3'b111;

   int checks = 0;
   int errors = 0;

   logic [16:0] ctl_vec;
   logic [2:0]  status;

   assign ctl_vec = {ctl_reg_sel_gp, ctl_reg_sel_gp_16, ctl_reg_sel_sp, ctl_reg_gp_oe,
                     ctl_reg_use_sp, ctl_reg_sel_wz, ctl_reg_sel_pc, ctl_reg_sel_ir,
                     ctl_reg_sel_sys_hi, ctl_reg_sel_sys_lo, ctl_reg_sys_oe,
                     ctl_reg_use_ixiy, ctl_reg_use_ix,
                     ctl_reg_exx, ctl_reg_ex_af, ctl_reg_ex_de_hl, ctl_sw_4};
   assign status  = {cmd_if.cmd_ready, done, err};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cycle(input string tag, input logic [16:0] ctl_exp,
                            input logic [2:0] st_exp, input logic [2:0] rs_exp);
      chk({tag, " ctl"}, ctl_vec, ctl_exp);
      chk({tag, " status"}, {14'd0, status}, {14'd0, st_exp});
      chk({tag, " reg_sel"}, {14'd0, reg_sel}, {14'd0, rs_exp});
   endtask

   task automatic send(input logic [2:0] op, input logic sys, input logic [2:0] sel,
                       input logic hi, input logic sp, input logic ixiy, input logic ix,
                       input logic bridge);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_op     = op;
      cmd_if.cmd_sys    = sys;
      cmd_if.cmd_sel    = sel;
      cmd_if.cmd_hi     = hi;
      cmd_if.cmd_sp     = sp;
      cmd_if.cmd_ixiy   = ixiy;
      cmd_if.cmd_ix     = ix;
      cmd_if.cmd_bridge = bridge;
      tick();
      cmd_if.cmd_valid  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_op     = 3'd0;
      cmd_if.cmd_sys    = 1'b0;
      cmd_if.cmd_sel    = 3'd0;
      cmd_if.cmd_hi     = 1'b0;
      cmd_if.cmd_sp     = 1'b0;
      cmd_if.cmd_ixiy   = 1'b0;
      cmd_if.cmd_ix     = 1'b0;
      cmd_if.cmd_bridge = 1'b0;
      tick();
      tick();
      chk_cycle("reset", C_NONE, S_IDLE, 3'd0);
      reset = 1'b0;
      tick();
      chk_cycle("idle", C_NONE, S_IDLE, 3'd0);

      // GP RD16 with SP replacing AF
      send(3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_cycle("rd16 ph", C_SEL_GP | C_GP_16 | C_SEL_SP | C_GP_OE, S_BUSY, 3'd0);
      tick();
      chk_cycle("rd16 done", C_NONE, S_DONE, 3'd0);

      // SYS WR16 WZ: lo for 2 cycles then hi for 2 cycles
      send(3'd4, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("wr16 c1", C_WZ | C_LO, S_BUSY, 3'd0);
      tick();
      chk_cycle("wr16 c2", C_WZ | C_LO, S_BUSY, 3'd0);
      tick();
      chk_cycle("wr16 c3", C_WZ | C_HI, S_BUSY, 3'd0);
      tick();
      chk_cycle("wr16 c4", C_WZ | C_HI, S_BUSY, 3'd0);
      tick();
      chk_cycle("wr16 done", C_NONE, S_DONE, 3'd0);

      // Reset during the high phase of SYS WR16 PC
      send(3'd4, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk_cycle("abort ph_hi", C_PC | C_HI, S_BUSY, 3'd0);
      reset = 1'b1;
      tick();
      chk_cycle("abort reset", C_NONE, S_IDLE, 3'd0);
      reset = 1'b0;
      tick();
      chk_cycle("abort no done", C_NONE, S_IDLE, 3'd0);

      // EXX then an EXAF held on the port until it is accepted
      send(3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'd6;
      chk_cycle("exx c1", C_EXX, S_BUSY, 3'd0);
      tick();
      chk_cycle("exx gap1", C_NONE, S_BUSY, 3'd0);
      tick();
      chk_cycle("exx gap2", C_NONE, S_BUSY, 3'd0);
      tick();
      chk_cycle("exx done", C_NONE, S_DONE, 3'd0);
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk_cycle("exaf c1", C_EXAF, S_BUSY, 3'd0);
      tick();
      chk_cycle("exaf gap1", C_NONE, S_BUSY, 3'd0);
      tick();
      chk_cycle("exaf gap2", C_NONE, S_BUSY, 3'd0);
      tick();
      chk_cycle("exaf done", C_NONE, S_DONE, 3'd0);

      // SYS RD8 high byte of PC
      send(3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("rd8 pc hi", C_PC | C_HI | C_SYS_OE, S_BUSY, 3'd0);
      tick();
      chk_cycle("rd8 pc done", C_NONE, S_DONE, 3'd0);

      // GP WR8 held for two cycles
      send(3'd3, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("wr8 c1", C_SEL_GP, S_BUSY, 3'd7);
      tick();
      chk_cycle("wr8 c2", C_SEL_GP, S_BUSY, 3'd7);
      tick();
      chk_cycle("wr8 done", C_NONE, S_DONE, 3'd0);

      // Illegal SYS select sets sticky err
      send(3'd1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("illegal", C_NONE, S_DONE_E, 3'd0);
      tick();
      chk_cycle("illegal after", C_NONE, S_IDLE_E, 3'd0);

      send(3'd1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("rd8 after err", C_SEL_GP | C_GP_OE, S_BUSY_E, 3'd3);
      tick();
      chk_cycle("rd8 after err done", C_NONE, S_DONE_E, 3'd0);

      // Illegal exchange on a system register
      send(3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("illegal ex", C_NONE, S_DONE_E, 3'd0);

      // GP RD8 HL with IY substitution and bus bridge
      send(3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_cycle("rd8 iy", C_SEL_GP | C_GP_OE | C_IXIY | C_SW4, S_BUSY_E, 3'd2);
      tick();
      chk_cycle("rd8 iy done", C_NONE, S_DONE_E, 3'd0);

      // NOP completes one cycle after acceptance
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle("nop", C_NONE, S_DONE_E, 3'd0);
      tick();
      chk_cycle("nop after", C_NONE, S_IDLE_E, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
